// File: rtl/cornet_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cornet_bus_pkg
// Brief  : Shared types and constants for the cornet memory-port arbiter.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package cornet_bus_pkg;

  localparam int unsigned NUM_REQ_DEF      = 3;
  localparam int unsigned GRANT_W          = $clog2(NUM_REQ_DEF);
  localparam logic [7:0]  TIMEOUT_DATA_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS_RD = 2'd1,
    ST_ACCESS_WR = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cornet_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cornet_rr_picker
// Brief  : Combinational winner selection: locked master if locked,
//          otherwise round-robin starting after the last grant.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module cornet_rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned GNT_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GNT_W-1:0]   last_i,
  input  logic               lock_i,
  input  logic [GNT_W-1:0]   lock_id_i,
  output logic [GNT_W-1:0]   win_o,
  output logic               any_o
);

  logic             hi_found;
  logic             lo_found;
  logic [GNT_W-1:0] hi_win;
  logic [GNT_W-1:0] lo_win;

  // Scan high-to-low so the lowest index above / at-or-below last survives.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        if (GNT_W'(j) > last_i) begin
          hi_found = 1'b1;
          hi_win   = GNT_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_win   = GNT_W'(j);
        end
      end
    end
  end

  // Under lock only the locked master may win; nobody else is considered.
  always_comb begin
    if (lock_i) begin
      any_o = req_i[lock_id_i];
      win_o = lock_id_i;
    end else begin
      any_o = hi_found | lo_found;
      win_o = hi_found ? hi_win : lo_win;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cornet_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cornet_bus_arbiter
// Brief  : Round-robin arbiter sharing one memory port between bus masters,
//          with word-transfer lock and a read-timeout watchdog.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module cornet_bus_arbiter
  import cornet_bus_pkg::*;
#(
  parameter int unsigned         NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned         ADDR_W         = 16,
  parameter int unsigned         DATA_W         = 8,
  parameter int unsigned         TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]   TIMEOUT_DATA   = DATA_W'(TIMEOUT_DATA_DEF),
  parameter int unsigned         GNT_W          = idx_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  output logic                      mem_wr_enable,
  output logic                      mem_rd_req,
  input  logic                      mem_rd_ack,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  localparam int unsigned CNT_W = idx_width(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                mem_wr_enable_q, mem_wr_enable_d;
  logic                mem_rd_req_q, mem_rd_req_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [GNT_W-1:0]    grant_id_q, grant_id_d;
  logic [GNT_W-1:0]    last_q, last_d;
  logic                lock_q, lock_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_set;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr[NUM_REQ];
  logic [NUM_REQ-1:0]  req_eligible;
  logic [GNT_W-1:0]    win;
  logic                win_any;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // A master still sees its ack this cycle and holds req_valid until the
  // next edge; hide it so the same request is not granted twice.
  assign req_eligible = req_valid & ~req_ack_q;

  cornet_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_picker (
    .req_i     (req_eligible),
    .last_i    (last_q),
    .lock_i    (lock_q),
    .lock_id_i (grant_id_q),
    .win_o     (win),
    .any_o     (win_any)
  );

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d         = state_q;
    mem_addr_d      = mem_addr_q;
    mem_wr_data_d   = mem_wr_data_q;
    mem_wr_enable_d = 1'b0;
    mem_rd_req_d    = mem_rd_req_q;
    rd_data_d       = rd_data_q;
    grant_id_d      = grant_id_q;
    last_d          = last_q;
    lock_d          = lock_q;
    req_ack_d       = '0;
    cnt_d           = cnt_q;
    timeout_set     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (lock_q && !req_valid[grant_id_q]) begin
          lock_d = 1'b0;
        end
        if (win_any) begin
          mem_addr_d    = addr_arr[win];
          mem_wr_data_d = wdata_arr[win];
          grant_id_d    = win;
          last_d        = win;
          cnt_d         = '0;
          if (req_we[win]) begin
            mem_wr_enable_d = 1'b1;
            state_d         = ST_ACCESS_WR;
          end else begin
            mem_rd_req_d = 1'b1;
            state_d      = ST_ACCESS_RD;
          end
        end
      end
      ST_ACCESS_WR: begin
        state_d = ST_DONE;
      end
      ST_ACCESS_RD: begin
        if (mem_rd_ack) begin
          rd_data_d    = mem_rd_data;
          mem_rd_req_d = 1'b0;
          state_d      = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rd_data_d    = TIMEOUT_DATA;
          mem_rd_req_d = 1'b0;
          timeout_set  = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        req_ack_d[grant_id_q] = 1'b1;
        lock_d                = req_lock[grant_id_q];
        state_d               = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      mem_addr_q      <= '0;
      mem_wr_data_q   <= '0;
      mem_wr_enable_q <= 1'b0;
      mem_rd_req_q    <= 1'b0;
      rd_data_q       <= '0;
      grant_id_q      <= '0;
      last_q          <= GNT_W'(NUM_REQ - 1);
      lock_q          <= 1'b0;
      req_ack_q       <= '0;
      timeout_err_q   <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      mem_addr_q      <= mem_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      mem_wr_enable_q <= mem_wr_enable_d;
      mem_rd_req_q    <= mem_rd_req_d;
      rd_data_q       <= rd_data_d;
      grant_id_q      <= grant_id_d;
      last_q          <= last_d;
      lock_q          <= lock_d;
      req_ack_q       <= req_ack_d;
      timeout_err_q   <= timeout_err_d;
      cnt_q           <= cnt_d;
    end
  end

  assign req_ack       = req_ack_q;
  assign rd_data       = rd_data_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_wr_enable = mem_wr_enable_q;
  assign mem_rd_req    = mem_rd_req_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_err   = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cornet_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_cornet_bus_arbiter
// Brief  : Scoreboard bench for cornet_bus_arbiter: expected memory accesses
//          and completions are queued by the stimulus and popped by monitors.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_cornet_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_we, req_lock;
  logic [47:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_ack;
  logic [7:0]  rd_data, mem_wr_data, mem_rd_data;
  logic [15:0] mem_addr;
  logic        mem_wr_enable, mem_rd_req, mem_rd_ack;
  logic [1:0]  grant_id;
  logic        busy, timeout_err, err_clr;

  cornet_bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ack       (req_ack),
    .rd_data       (rd_data),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_enable (mem_wr_enable),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_ack    (mem_rd_ack),
    .mem_rd_data   (mem_rd_data),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    bit         we;
    logic [7:0] rdata;
  } ack_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_t;

  ack_t exp_ack_q[$];
  mem_t exp_mem_q[$];

  int n_vec = 0;
  int n_err = 0;

  int mem_delay = 2;
  bit no_ack    = 1'b0;
  int rd_hi     = 0;
  int rd_cnt    = 0;
  bit prev_rd   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return (a == 16'h0444) ? 8'hA9 : (a[7:0] ^ 8'h3C);
  endfunction

  // Memory responder: acks a read mem_delay cycles after mem_rd_req rises.
  initial begin
    mem_rd_ack  = 1'b0;
    mem_rd_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd_req) rd_hi++;
      if (reset || mem_rd_ack) begin
        mem_rd_ack = 1'b0;
        rd_cnt     = 0;
      end else if (mem_rd_req) begin
        rd_cnt++;
        if (!no_ack && rd_cnt == mem_delay + 1) begin
          mem_rd_ack  = 1'b1;
          mem_rd_data = mem_model(mem_addr);
        end
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (req_ack != 3'b000) begin
      if (exp_ack_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: req_ack=%b with nothing expected at %0t", req_ack, $time);
      end else begin
        ack_t e;
        e = exp_ack_q.pop_front();
        chk("ack_id", 32'(req_ack), 32'(3'b001 << e.id));
        if (!e.we) chk("rd_data", 32'(rd_data), 32'(e.rdata));
      end
    end
  end

  // Memory-side monitor: each write strobe cycle and each read start pops one entry.
  always @(negedge clk) begin
    if (mem_wr_enable || (mem_rd_req && !prev_rd)) begin
      if (exp_mem_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_mem: we=%b rd=%b addr=0x%h with nothing expected", mem_wr_enable, mem_rd_req, mem_addr);
      end else begin
        mem_t m;
        m = exp_mem_q.pop_front();
        chk("mem_we", 32'(mem_wr_enable), 32'(m.we));
        chk("mem_addr", 32'(mem_addr), 32'(m.addr));
        chk("rd_wr_overlap", 32'(mem_rd_req & mem_wr_enable), 32'd0);
        if (m.we) chk("mem_wdata", 32'(mem_wr_data), 32'(m.wdata));
      end
    end
    prev_rd = mem_rd_req;
  end

  task automatic push_ack(input int id, input bit we, input logic [7:0] rd);
    ack_t e;
    e.id = id; e.we = we; e.rdata = rd;
    exp_ack_q.push_back(e);
  endtask

  task automatic push_mem(input bit we, input logic [15:0] a, input logic [7:0] wd);
    mem_t m;
    m.we = we; m.addr = a; m.wdata = wd;
    exp_mem_q.push_back(m);
  endtask

  task automatic wait_ack(input int id, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (req_ack[id]) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_wait_m%0d: no req_ack within %0d cycles", id, cyc);
    end
  endtask

  task automatic do_access(input int id, input bit we, input logic [15:0] a,
                           input logic [7:0] wd, input bit lk, input int exp_lat);
    int cyc;
    req_valid[id]        = 1'b1;
    req_we[id]           = we;
    req_lock[id]         = lk;
    req_addr[id*16 +: 16] = a;
    req_wdata[id*8 +: 8]  = wd;
    wait_ack(id, cyc);
    if (cyc < 400) chk("latency", 32'(cyc), 32'(exp_lat));
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    req_lock[id]  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int done_cnt[3];
    bit prev_ack[3];
    int total;

    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    err_clr   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_enable), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // CPU read 0x0444, memory answers 0xA9 two cycles after mem_rd_req.
    push_mem(1'b0, 16'h0444, 8'h00);
    push_ack(0, 1'b0, 8'hA9);
    do_access(0, 1'b0, 16'h0444, 8'h00, 1'b0, 5);

    // Master 2 write 0x9000 <= 0x5A.
    push_mem(1'b1, 16'h9000, 8'h5A);
    push_ack(2, 1'b1, 8'h00);
    do_access(2, 1'b1, 16'h9000, 8'h5A, 1'b0, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("grant_hold", 32'(grant_id), 32'd2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Locked word read by the CPU while master 1 waits.
    do_reset();
    req_valid[1]      = 1'b1;
    req_we[1]         = 1'b0;
    req_addr[31:16]   = 16'h3000;
    push_mem(1'b0, 16'h1000, 8'h00);
    push_mem(1'b0, 16'h1001, 8'h00);
    push_mem(1'b0, 16'h3000, 8'h00);
    push_ack(0, 1'b0, 8'h3C);
    push_ack(0, 1'b0, 8'h3D);
    push_ack(1, 1'b0, 8'h3C);
    do_access(0, 1'b0, 16'h1000, 8'h00, 1'b1, 5);
    do_access(0, 1'b0, 16'h1001, 8'h00, 1'b0, 5);
    wait_ack(1, cyc);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;

    // Read timeout: memory never answers.
    no_ack = 1'b1;
    rd_hi  = 0;
    push_mem(1'b0, 16'h0500, 8'h00);
    push_ack(0, 1'b0, 8'hFF);
    do_access(0, 1'b0, 16'h0500, 8'h00, 1'b0, 257);
    chk("timeout_rd_req_cycles", 32'(rd_hi), 32'd255);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("timeout_err_clr", 32'(timeout_err), 32'd0);

    // Reset asserted in the middle of a read by master 1.
    push_mem(1'b0, 16'h3100, 8'h00);
    req_valid[1]    = 1'b1;
    req_we[1]       = 1'b0;
    req_addr[31:16] = 16'h3100;
    repeat (4) @(posedge clk);
    #1;
    chk("inflight_busy", 32'(busy), 32'd1);
    chk("inflight_grant", 32'(grant_id), 32'd1);
    chk("inflight_rd_req", 32'(mem_rd_req), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req_ack", 32'(req_ack), 32'd0);
    req_valid = '0;
    no_ack    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // All three masters writing continuously: expect 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      int id;
      int r;
      id = k % 3;
      r  = k / 3;
      push_ack(id, 1'b1, 8'h00);
      push_mem(1'b1, 16'(16'h2000 + id * 16'h0100 + r), 8'(id * 16 + r));
    end
    for (int i = 0; i < 3; i++) begin
      done_cnt[i]          = 0;
      prev_ack[i]          = 1'b0;
      req_valid[i]         = 1'b1;
      req_we[i]            = 1'b1;
      req_addr[i*16 +: 16] = 16'(16'h2000 + i * 16'h0100);
      req_wdata[i*8 +: 8]  = 8'(i * 16);
    end
    total = 0;
    for (int c = 0; c < 200 && total < 6; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && prev_ack[i]) begin
          req_valid[i] = 1'b0;
          done_cnt[i]++;
          total++;
        end else if (!req_valid[i] && done_cnt[i] < 2) begin
          req_valid[i]         = 1'b1;
          req_addr[i*16 +: 16] = 16'(16'h2000 + i * 16'h0100 + done_cnt[i]);
          req_wdata[i*8 +: 8]  = 8'(i * 16 + done_cnt[i]);
        end
      end
      for (int i = 0; i < 3; i++) prev_ack[i] = req_ack[i];
    end
    chk("rr_completions", 32'(total), 32'd6);

    repeat (5) @(posedge clk);
    #1;
    chk("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
